// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
// The state enum is shared so the arbiter and any debug logic decode states the same way.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } arb_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Only a complete write (AW together with W) or a read counts as a request.
    function automatic logic is_request(input logic awvalid, input logic wvalid,
                                        input logic arvalid);
        return arvalid | (awvalid & wvalid);
    endfunction

endpackage

// File: rtl/axil_rr_arbiter_if.sv
// AXI4-Lite bundle for N ports packed side by side; port i occupies slice i of every field.
// Use N=1 for the single slave-facing port.
interface axil_rr_arbiter_if #(
    parameter int N  = 1,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8
);
    logic [N*AW-1:0] awaddr;
    logic [N*3-1:0]  awprot;
    logic [N-1:0]    awvalid;
    logic [N-1:0]    awready;

    logic [N*DW-1:0] wdata;
    logic [N*SW-1:0] wstrb;
    logic [N-1:0]    wvalid;
    logic [N-1:0]    wready;

    logic [N*2-1:0]  bresp;
    logic [N-1:0]    bvalid;
    logic [N-1:0]    bready;

    logic [N*AW-1:0] araddr;
    logic [N*3-1:0]  arprot;
    logic [N-1:0]    arvalid;
    logic [N-1:0]    arready;

    logic [N*DW-1:0] rdata;
    logic [N*2-1:0]  rresp;
    logic [N-1:0]    rvalid;
    logic [N-1:0]    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first set bit of req scanning from last+1, wrapping mod S_COUNT.
// Purely combinational, zero latency.
module rr_picker #(
    parameter int S_COUNT = 2
) (
    input  logic [S_COUNT-1:0]         req,
    input  logic [$clog2(S_COUNT)-1:0] last,
    output logic [$clog2(S_COUNT)-1:0] idx,
    output logic                       found
);
    localparam int GW = $clog2(S_COUNT);

    always_comb begin
        int pos;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        // Scan from the far end so the nearest position after last is the final winner.
        for (int k = S_COUNT; k >= 1; k--) begin
            pos = (int'(last) + k) % S_COUNT;
            if (req[pos]) begin
                idx   = GW'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Round-robin AXI4-Lite arbiter: one complete read or write at a time from the granted master.
// One IDLE cycle per transaction; channels are combinational pass-through, backpressure follows the slave.
module axil_rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int S_COUNT    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    axil_rr_arbiter_if.slave           s_axil,
    axil_rr_arbiter_if.master          m_axil,
    output logic [$clog2(S_COUNT)-1:0] grant,
    output logic                       busy
);
    localparam int GW = $clog2(S_COUNT);

    arb_state_t          r_state;
    logic [GW-1:0]       r_last;
    logic [GW-1:0]       r_grant;
    logic                r_aw_done;
    logic                r_w_done;
    logic                r_busy;

    logic [S_COUNT-1:0]  w_req;
    logic [S_COUNT-1:0]  w_wr_req;
    logic [GW-1:0]       w_pick_idx;
    logic                w_pick_found;
    int                  w_gi;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_ar_hs;
    logic                w_r_hs;

    assign grant = r_grant;
    assign busy  = r_busy;
    assign w_gi  = int'(r_grant);

    always_comb begin
        w_req    = '0;
        w_wr_req = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            w_wr_req[i] = s_axil.awvalid[i] & s_axil.wvalid[i];
            w_req[i]    = is_request(s_axil.awvalid[i], s_axil.wvalid[i], s_axil.arvalid[i]);
        end
    end

    rr_picker #(.S_COUNT(S_COUNT)) u_picker (
        .req   (w_req),
        .last  (r_last),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_aw_hs = (r_state == WR_ADDR) & ~r_aw_done & s_axil.awvalid[r_grant] & m_axil.awready[0];
    assign w_w_hs  = (r_state == WR_ADDR) & ~r_w_done  & s_axil.wvalid[r_grant]  & m_axil.wready[0];
    assign w_b_hs  = (r_state == WR_RESP) & m_axil.bvalid[0] & s_axil.bready[r_grant];
    assign w_ar_hs = (r_state == RD_ADDR) & s_axil.arvalid[r_grant] & m_axil.arready[0];
    assign w_r_hs  = (r_state == RD_DATA) & m_axil.rvalid[0] & s_axil.rready[r_grant];

    // Everything is decoded from the state register so reset clears all outputs at once.
    always_comb begin
        m_axil.awaddr  = '0;
        m_axil.awprot  = '0;
        m_axil.awvalid = '0;
        m_axil.wdata   = '0;
        m_axil.wstrb   = '0;
        m_axil.wvalid  = '0;
        m_axil.bready  = '0;
        m_axil.araddr  = '0;
        m_axil.arprot  = '0;
        m_axil.arvalid = '0;
        m_axil.rready  = '0;
        s_axil.awready = '0;
        s_axil.wready  = '0;
        s_axil.bresp   = '0;
        s_axil.bvalid  = '0;
        s_axil.arready = '0;
        s_axil.rdata   = '0;
        s_axil.rresp   = '0;
        s_axil.rvalid  = '0;
        case (r_state)
            WR_ADDR: begin
                m_axil.awaddr           = s_axil.awaddr[w_gi*ADDR_WIDTH +: ADDR_WIDTH];
                m_axil.awprot           = s_axil.awprot[w_gi*3 +: 3];
                m_axil.awvalid[0]       = s_axil.awvalid[r_grant] & ~r_aw_done;
                s_axil.awready[r_grant] = m_axil.awready[0] & ~r_aw_done;
                m_axil.wdata            = s_axil.wdata[w_gi*DATA_WIDTH +: DATA_WIDTH];
                m_axil.wstrb            = s_axil.wstrb[w_gi*STRB_WIDTH +: STRB_WIDTH];
                m_axil.wvalid[0]        = s_axil.wvalid[r_grant] & ~r_w_done;
                s_axil.wready[r_grant]  = m_axil.wready[0] & ~r_w_done;
            end
            WR_RESP: begin
                s_axil.bresp            = {S_COUNT{m_axil.bresp}};
                s_axil.bvalid[r_grant]  = m_axil.bvalid[0];
                m_axil.bready[0]        = s_axil.bready[r_grant];
            end
            RD_ADDR: begin
                m_axil.araddr           = s_axil.araddr[w_gi*ADDR_WIDTH +: ADDR_WIDTH];
                m_axil.arprot           = s_axil.arprot[w_gi*3 +: 3];
                m_axil.arvalid[0]       = s_axil.arvalid[r_grant];
                s_axil.arready[r_grant] = m_axil.arready[0];
            end
            RD_DATA: begin
                s_axil.rdata            = {S_COUNT{m_axil.rdata}};
                s_axil.rresp            = {S_COUNT{m_axil.rresp}};
                s_axil.rvalid[r_grant]  = m_axil.rvalid[0];
                m_axil.rready[0]        = s_axil.rready[r_grant];
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_last    <= GW'(S_COUNT - 1);
            r_grant   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        r_grant   <= w_pick_idx;
                        r_busy    <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= w_wr_req[w_pick_idx] ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    // AW and W may complete in either order or together.
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= WR_RESP;
                    end else begin
                        r_aw_done <= r_aw_done | w_aw_hs;
                        r_w_done  <= r_w_done | w_w_hs;
                    end
                end
                WR_RESP: begin
                    if (w_b_hs) begin
                        r_last  <= r_grant;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_r_hs) begin
                        r_last  <= r_grant;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Random two-master traffic against a randomly stalling slave, checked by a transaction-level model.
module tb_axil_rr_arbiter;
    import axil_arb_pkg::*;

    localparam int S  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [0:0] grant;
    logic       busy;

    axil_rr_arbiter_if #(.N(S), .AW(AW), .DW(DW)) s_if ();
    axil_rr_arbiter_if #(.N(1), .AW(AW), .DW(DW)) m_if ();

    axil_rr_arbiter #(.S_COUNT(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axil  (s_if.slave),
        .m_axil  (m_if.master),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // master side: 0 idle, 1 write issue, 2 wait B, 3 read issue, 4 wait R
    int            ms      [S];
    logic [AW-1:0] maddr   [S];
    logic [DW-1:0] mdata   [S];
    logic [SW-1:0] mstrb   [S];
    int            wdelay  [S];
    bit            aw_ok   [S];
    bit            w_ok    [S];
    int            n_grants[S];

    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] slv_mem [16];
    bit            gen_en, hold_r;
    bit            slv_aw_got, slv_w_got, slv_b_pend, slv_r_pend;
    logic [AW-1:0] slv_awaddr;
    logic [DW-1:0] slv_wdata, slv_rdata;
    logic [SW-1:0] slv_wstrb;

    bit mdl_busy, mdl_first, mdl_is_wr;
    int mdl_last, mdl_grant, busy_cnt;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] st);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic clear_inputs();
        s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = '0;
        s_if.wdata  = '0; s_if.wstrb  = '0; s_if.wvalid  = '0;
        s_if.bready = '0;
        s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = '0;
        s_if.rready = '0;
        m_if.awready = '0; m_if.wready = '0; m_if.arready = '0;
        m_if.bresp = '0; m_if.bvalid = '0;
        m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = '0;
        for (int i = 0; i < S; i++) ms[i] = 0;
        slv_aw_got = 0; slv_w_got = 0; slv_b_pend = 0; slv_r_pend = 0;
    endtask

    task automatic start_txn(input int i);
        maddr[i] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        if ($urandom_range(0, 1) == 1) begin
            mdata[i]  = $urandom;
            mstrb[i]  = 4'($urandom_range(1, 15));
            wdelay[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            aw_ok[i]  = 0;
            w_ok[i]   = 0;
            s_if.awaddr[AW*i +: AW] = maddr[i];
            s_if.awprot[3*i +: 3]   = 3'($urandom_range(0, 7));
            s_if.awvalid[i]         = 1'b1;
            s_if.wdata[DW*i +: DW]  = mdata[i];
            s_if.wstrb[SW*i +: SW]  = mstrb[i];
            s_if.wvalid[i]          = (wdelay[i] == 0);
            ms[i] = 1;
        end else begin
            s_if.araddr[AW*i +: AW] = maddr[i];
            s_if.arprot[3*i +: 3]   = 3'($urandom_range(0, 7));
            s_if.arvalid[i]         = 1'b1;
            ms[i] = 3;
        end
    endtask

    // One clock: observe at the falling edge, then drive new inputs just after the rising edge.
    task automatic step();
        bit hs_aw [S];
        bit hs_w  [S];
        bit hs_b  [S];
        bit hs_ar [S];
        bit hs_r  [S];
        bit m_aw, m_w, m_b, m_ar, m_r;
        logic [S-1:0] req, mask;
        int pick, c;
        @(negedge aclk);
        for (int i = 0; i < S; i++) begin
            hs_aw[i] = s_if.awvalid[i] & s_if.awready[i];
            hs_w[i]  = s_if.wvalid[i]  & s_if.wready[i];
            hs_b[i]  = s_if.bvalid[i]  & s_if.bready[i];
            hs_ar[i] = s_if.arvalid[i] & s_if.arready[i];
            hs_r[i]  = s_if.rvalid[i]  & s_if.rready[i];
        end
        m_aw = m_if.awvalid[0] & m_if.awready[0];
        m_w  = m_if.wvalid[0]  & m_if.wready[0];
        m_b  = m_if.bvalid[0]  & m_if.bready[0];
        m_ar = m_if.arvalid[0] & m_if.arready[0];
        m_r  = m_if.rvalid[0]  & m_if.rready[0];

        if (mdl_first) begin
            mdl_first = 0;
            check_eq("grant", grant, mdl_grant);
            check_eq("busy_on", busy, 1);
            if (mdl_is_wr) begin
                check_eq("m_aw_w_valid", {m_if.awvalid, m_if.wvalid}, 2'b11);
                check_eq("m_awaddr", m_if.awaddr, maddr[mdl_grant]);
                check_eq("m_wdata", m_if.wdata, mdata[mdl_grant]);
            end else begin
                check_eq("m_arvalid", m_if.arvalid, 1);
                check_eq("m_araddr", m_if.araddr, maddr[mdl_grant]);
            end
        end

        if (!mdl_busy) begin
            check_eq("idle_busy", busy, 0);
            check_eq("idle_m_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 0);
            for (int i = 0; i < S; i++)
                req[i] = (s_if.awvalid[i] & s_if.wvalid[i]) | s_if.arvalid[i];
            pick = -1;
            for (int k = 1; k <= S; k++) begin
                c = (mdl_last + k) % S;
                if (pick < 0 && req[c]) pick = c;
            end
            if (pick >= 0) begin
                mdl_busy  = 1;
                mdl_first = 1;
                mdl_grant = pick;
                mdl_is_wr = s_if.awvalid[pick] & s_if.wvalid[pick];
                n_grants[pick]++;
            end
        end else begin
            mask = '1;
            mask[mdl_grant] = 1'b0;
            check_eq("isolation",
                     (s_if.awready | s_if.wready | s_if.arready | s_if.bvalid | s_if.rvalid) & mask, 0);
            busy_cnt++;
            if (m_b || m_r) begin
                mdl_busy = 0;
                mdl_last = mdl_grant;
                busy_cnt = 0;
            end else if (busy_cnt > 400) begin
                check_eq("busy_timeout", busy_cnt, 0);
                mdl_busy = 0;
                busy_cnt = 0;
            end
        end

        for (int i = 0; i < S; i++) begin
            if (hs_b[i]) begin
                check_eq("bresp", s_if.bresp[2*i +: 2], AXI_RESP_OKAY);
                ref_mem[maddr[i][5:2]] = merge(ref_mem[maddr[i][5:2]], mdata[i], mstrb[i]);
            end
            if (hs_r[i]) begin
                check_eq("rdata", s_if.rdata[DW*i +: DW], ref_mem[maddr[i][5:2]]);
                check_eq("rresp", s_if.rresp[2*i +: 2], AXI_RESP_OKAY);
            end
        end

        if (m_aw) begin slv_aw_got = 1; slv_awaddr = m_if.awaddr; end
        if (m_w)  begin slv_w_got = 1; slv_wdata = m_if.wdata; slv_wstrb = m_if.wstrb; end
        if (m_ar) begin slv_r_pend = 1; slv_rdata = slv_mem[m_if.araddr[5:2]]; end
        if (m_b)  slv_b_pend = 0;
        if (m_r)  slv_r_pend = 0;
        if (slv_aw_got && slv_w_got) begin
            slv_mem[slv_awaddr[5:2]] = merge(slv_mem[slv_awaddr[5:2]], slv_wdata, slv_wstrb);
            slv_aw_got = 0;
            slv_w_got  = 0;
            slv_b_pend = 1;
        end

        @(posedge aclk);
        #1;
        for (int i = 0; i < S; i++) begin
            s_if.bready[i] = ($urandom_range(0, 3) != 0);
            s_if.rready[i] = ($urandom_range(0, 3) != 0);
            case (ms[i])
                0: if (gen_en && $urandom_range(0, 2) == 0) start_txn(i);
                1: begin
                    if (hs_aw[i]) begin s_if.awvalid[i] = 1'b0; aw_ok[i] = 1; end
                    if (hs_w[i])  begin s_if.wvalid[i]  = 1'b0; w_ok[i]  = 1; end
                    if (!w_ok[i] && !s_if.wvalid[i]) begin
                        if (wdelay[i] > 0) wdelay[i]--;
                        if (wdelay[i] == 0) s_if.wvalid[i] = 1'b1;
                    end
                    if (aw_ok[i] && w_ok[i]) ms[i] = 2;
                end
                2: if (hs_b[i]) ms[i] = 0;
                3: if (hs_ar[i]) begin s_if.arvalid[i] = 1'b0; ms[i] = 4; end
                4: if (hs_r[i]) ms[i] = 0;
                default: ;
            endcase
        end
        m_if.awready[0] = !slv_aw_got && !slv_b_pend && ($urandom_range(0, 2) != 0);
        m_if.wready[0]  = !slv_w_got  && !slv_b_pend && ($urandom_range(0, 2) != 0);
        m_if.arready[0] = !slv_r_pend && ($urandom_range(0, 2) != 0);
        m_if.bresp      = AXI_RESP_OKAY;
        m_if.rresp      = AXI_RESP_OKAY;
        if (!slv_b_pend) m_if.bvalid[0] = 1'b0;
        else if (!m_if.bvalid[0] && $urandom_range(0, 1) == 1) m_if.bvalid[0] = 1'b1;
        if (!slv_r_pend) m_if.rvalid[0] = 1'b0;
        else if (!m_if.rvalid[0] && !hold_r && $urandom_range(0, 1) == 1) begin
            m_if.rvalid[0] = 1'b1;
            m_if.rdata     = slv_rdata;
        end
    endtask

    function automatic bit all_quiet();
        bit q;
        q = !mdl_busy;
        for (int i = 0; i < S; i++) if (ms[i] != 0) q = 0;
        return q;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!all_quiet() && n < 300) begin
            step();
            n++;
        end
        check_eq(tag, all_quiet(), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
            ref_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
        end
        gen_en = 0; hold_r = 0;
        mdl_busy = 0; mdl_first = 0; mdl_last = S - 1; mdl_grant = 0; busy_cnt = 0;
        for (int i = 0; i < S; i++) n_grants[i] = 0;

        // Requests and slave readiness active while in reset must not leak through.
        s_if.awvalid = '1; s_if.wvalid = '1; s_if.arvalid = '1;
        s_if.awaddr  = {S{32'hA5A5_0040}};
        s_if.bready  = '1; s_if.rready = '1;
        m_if.awready = '1; m_if.wready = '1; m_if.arready = '1;
        m_if.bvalid  = '1; m_if.rvalid = '1; m_if.rdata = 32'h5555_AAAA;
        #23;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_m_valid", {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 0);
        check_eq("rst_m_ready", {m_if.bready, m_if.rready}, 0);
        check_eq("rst_s_ready", {s_if.awready, s_if.wready, s_if.arready}, 0);
        check_eq("rst_s_valid", {s_if.bvalid, s_if.rvalid}, 0);
        check_eq("rst_m_awaddr", m_if.awaddr, 0);
        check_eq("rst_s_rdata", s_if.rdata, 0);
        clear_inputs();
        @(posedge aclk);
        #1 aresetn = 1'b1;

        gen_en = 1;
        repeat (3000) step();
        gen_en = 0;
        drain("drain_random");
        check_eq("m0_served", n_grants[0] > 0, 1);
        check_eq("m1_served", n_grants[1] > 0, 1);

        // Park master 1 in the read-data phase, then abort it with reset.
        hold_r = 1;
        maddr[1] = 32'h8;
        s_if.araddr[AW +: AW] = 32'h8;
        s_if.arvalid[1] = 1'b1;
        ms[1] = 3;
        begin
            int n;
            n = 0;
            while (ms[1] != 4 && n < 50) begin step(); n++; end
        end
        check_eq("reach_rd_data", ms[1], 4);
        step();
        step();
        s_if.rready    = '0;
        m_if.rvalid[0] = 1'b1;
        m_if.rdata     = 32'h1234_5678;
        #1;
        check_eq("pre_abort_busy", busy, 1);
        check_eq("pre_abort_rvalid", s_if.rvalid, 2'b10);
        aresetn = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_grant", grant, 0);
        check_eq("abort_s_rvalid", s_if.rvalid, 0);
        check_eq("abort_s_rdata", s_if.rdata, 0);
        check_eq("abort_m_ready", {m_if.rready, m_if.bready}, 0);
        check_eq("abort_s_ready", {s_if.awready, s_if.wready, s_if.arready}, 0);

        clear_inputs();
        hold_r = 0; mdl_busy = 0; mdl_first = 0; mdl_last = S - 1; busy_cnt = 0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        // Both masters read together: master 0 must go first after reset.
        for (int i = 0; i < S; i++) begin
            maddr[i] = 32'(i * 4 + 16);
            s_if.araddr[AW*i +: AW] = maddr[i];
            s_if.arvalid[i] = 1'b1;
            ms[i] = 3;
        end
        drain("drain_post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
